// File: rtl/mult_accum.sv
// mult_accum: sums COUNT unsigned 10-bit products into an ACC_W-bit result.
// ACCUM collects products through a valid/ready handshake; HOLD presents the
// finished group sum until the downstream stage takes it.
// Optional build macro MULT_ACCUM_SAT_EN clamps the accumulator at its maximum
// value instead of wrapping when an addition carries out.
module mult_accum #(
   parameter int ACC_W = 16,
   parameter int COUNT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow
);

   // Counter is wide enough to hold COUNT itself, which keeps COUNT = 1 legal.
   localparam int                CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] add_result;

   // One extra bit on the adder exposes the carry out of bit ACC_W-1.
   assign sum = {1'b0, acc_reg} + {{(ACC_W - 9){1'b0}}, product};

`ifdef MULT_ACCUM_SAT_EN
   // Clamp at all-ones on carry; products are unsigned, so once clamped the
   // value can only stay at the maximum for the rest of the group.
   assign add_result = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   // Plain modulo-2^ACC_W wrap.
   assign add_result = sum[ACC_W-1:0];
`endif

   // Handshake outputs decode straight from registers so they are glitch free.
   assign in_ready  = (state_reg == ACCUM);
   assign out_valid = (state_reg == HOLD);
   assign acc_out   = acc_reg;
   assign overflow  = overflow_reg;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= ACCUM;
         acc_reg      <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Next-state and datapath decisions; clear overrides accept and handoff.
   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (clear) begin
         state_next    = ACCUM;
         acc_next      = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (in_valid) begin
                  acc_next      = add_result;
                  count_next    = count_reg + CNT_W'(1);
                  overflow_next = overflow_reg | sum[ACC_W];
                  if (count_reg == LAST) begin
                     state_next = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_next    = ACCUM;
                  acc_next      = '0;
                  count_next    = '0;
                  overflow_next = 1'b0;
               end
            end
            default: begin
               state_next = ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_accum.sv
// Self-checking bench for mult_accum: directed scenarios plus randomized groups
// compared against a sum-of-products reference model.
module tb_mult_accum;

   logic        clock = 1'b0;
   logic        reset;

   // Instance A: default parameters (ACC_W = 16, COUNT = 4)
   logic        clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, overflow_a;
   logic [9:0]  product_a;
   logic [15:0] acc_out_a;

   // Instance B: narrow accumulator (ACC_W = 10, COUNT = 2)
   logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, overflow_b;
   logic [9:0]  product_b;
   logic [9:0]  acc_out_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mult_accum #(.ACC_W(16), .COUNT(4)) dut_a (
      .clock(clock), .reset(reset), .clear(clear_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .product(product_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .acc_out(acc_out_a), .overflow(overflow_a)
   );

   mult_accum #(.ACC_W(10), .COUNT(2)) dut_b (
      .clock(clock), .reset(reset), .clear(clear_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .product(product_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .acc_out(acc_out_b), .overflow(overflow_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: total of the group's products, wrapped or clamped.
   task automatic model(input longint total, input int width, output int acc, output int ovf);
      longint maxv;
      maxv = (longint'(1) << width) - 1;
      ovf  = (total > maxv) ? 1 : 0;
`ifdef MULT_ACCUM_SAT_EN
      acc  = (total > maxv) ? int'(maxv) : int'(total);
`else
      acc  = int'(total % (maxv + 1));
`endif
   endtask

   // Present one product to A and hold it until it is taken (bounded).
   task automatic send_a(input int p);
      int waited = 0;
      in_valid_a = 1'b1;
      product_a  = 10'(p);
      while (!in_ready_a && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 50) check("send_a_timeout", 32'(0), 32'(1));
      @(negedge clock);
      in_valid_a = 1'b0;
   endtask

   task automatic send_b(input int p);
      int waited = 0;
      in_valid_b = 1'b1;
      product_b  = 10'(p);
      while (!in_ready_b && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 50) check("send_b_timeout", 32'(0), 32'(1));
      @(negedge clock);
      in_valid_b = 1'b0;
   endtask

   // Wait for A's result, stall for 'stall' cycles, check, then hand it off.
   task automatic result_a(input string tag, input int exp_acc, input int exp_ovf, input int stall);
      int waited = 0;
      while (!out_valid_a && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      check({tag, "_valid"}, 32'(out_valid_a), 32'(1));
      for (int i = 0; i < stall; i++) begin
         @(negedge clock);
         check({tag, "_hold_acc"}, 32'(acc_out_a), 32'(exp_acc));
         check({tag, "_hold_ready"}, 32'(in_ready_a), 32'(0));
      end
      check({tag, "_acc"}, 32'(acc_out_a), 32'(exp_acc));
      check({tag, "_ovf"}, 32'(overflow_a), 32'(exp_ovf));
      out_ready_a = 1'b1;
      @(negedge clock);
      out_ready_a = 1'b0;
      check({tag, "_done"}, 32'(out_valid_a), 32'(0));
   endtask

   task automatic result_b(input string tag, input int exp_acc, input int exp_ovf);
      int waited = 0;
      while (!out_valid_b && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      check({tag, "_valid"}, 32'(out_valid_b), 32'(1));
      check({tag, "_acc"}, 32'(acc_out_b), 32'(exp_acc));
      check({tag, "_ovf"}, 32'(overflow_b), 32'(exp_ovf));
      out_ready_b = 1'b1;
      @(negedge clock);
      out_ready_b = 1'b0;
      check({tag, "_done"}, 32'(out_valid_b), 32'(0));
   endtask

   initial begin
      int     e_acc, e_ovf, p;
      longint total;

      reset = 1'b1;
      clear_a = 1'b0; in_valid_a = 1'b0; product_a = '0; out_ready_a = 1'b0;
      clear_b = 1'b0; in_valid_b = 1'b0; product_b = '0; out_ready_b = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_valid", 32'(out_valid_a), 32'(0));
      check("rst_ready", 32'(in_ready_a), 32'(1));
      check("rst_acc", 32'(acc_out_a), 32'(0));
      check("rst_ovf", 32'(overflow_a), 32'(0));
      check("rst_valid_b", 32'(out_valid_b), 32'(0));
      reset = 1'b0;
      @(negedge clock);

      // Back-to-back 3,5,7,9 with out_ready high: one-cycle latency, then ready
      out_ready_a = 1'b1;
      send_a(3); send_a(5); send_a(7); send_a(9);
      check("b2b_valid", 32'(out_valid_a), 32'(1));
      check("b2b_acc", 32'(acc_out_a), 32'(24));
      check("b2b_ovf", 32'(overflow_a), 32'(0));
      check("b2b_ready_hold", 32'(in_ready_a), 32'(0));
      @(negedge clock);
      out_ready_a = 1'b0;
      check("b2b_after_valid", 32'(out_valid_a), 32'(0));
      check("b2b_after_ready", 32'(in_ready_a), 32'(1));

      // Same group stalled for 5 cycles while a 5th product waits upstream
      send_a(3); send_a(5); send_a(7); send_a(9);
      check("stall_valid", 32'(out_valid_a), 32'(1));
      in_valid_a = 1'b1;
      product_a  = 10'(11);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_acc", 32'(acc_out_a), 32'(24));
         check("stall_ready", 32'(in_ready_a), 32'(0));
         check("stall_valid_hold", 32'(out_valid_a), 32'(1));
      end
      out_ready_a = 1'b1;
      @(negedge clock);
      out_ready_a = 1'b0;
      check("handoff_valid", 32'(out_valid_a), 32'(0));
      check("handoff_ready", 32'(in_ready_a), 32'(1));
      check("handoff_acc", 32'(acc_out_a), 32'(0));
      @(negedge clock);
      in_valid_a = 1'b0;
      check("fifth_accepted", 32'(acc_out_a), 32'(11));
      send_a(1); send_a(2); send_a(3);
      result_a("after_stall", 17, 0, 0);

      // Clear mid-group discards the product presented with it
      send_a(100); send_a(200);
      clear_a = 1'b1; in_valid_a = 1'b1; product_a = 10'(50);
      @(negedge clock);
      clear_a = 1'b0; in_valid_a = 1'b0;
      check("clear_acc", 32'(acc_out_a), 32'(0));
      check("clear_valid", 32'(out_valid_a), 32'(0));
      send_a(1); send_a(2); send_a(3); send_a(4);
      result_a("clear_group", 10, 0, 0);

      // Asynchronous reset between edges after 3 of 4 accepts
      send_a(1); send_a(1); send_a(1);
      check("pre_reset_acc", 32'(acc_out_a), 32'(3));
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid_a), 32'(0));
      check("async_rst_acc", 32'(acc_out_a), 32'(0));
      check("async_rst_ready", 32'(in_ready_a), 32'(1));
      #1 reset = 1'b0;
      @(negedge clock);
      send_a(1); send_a(1); send_a(1); send_a(1);
      result_a("post_reset", 4, 0, 0);

      // Bubbles between products do not advance the count
      for (int i = 0; i < 4; i++) begin
         send_a(6);
         @(negedge clock);
         check("bubble_not_done", 32'(out_valid_a), 32'(i == 3 ? 1 : 0));
      end
      result_a("bubbles", 24, 0, 0);

      // Narrow accumulator overflow: 1023 + 1
      send_b(1023); send_b(1);
`ifdef MULT_ACCUM_SAT_EN
      result_b("ovf_b", 1023, 1);
`else
      result_b("ovf_b", 0, 1);
`endif
      send_b(5); send_b(6);
      result_b("ovf_cleared_b", 11, 0);

      // Randomized groups on A with random bubbles and output stalls
      for (int g = 0; g < 15; g++) begin
         total = 0;
         for (int k = 0; k < 4; k++) begin
            p = int'($urandom_range(0, 1023));
            total += p;
            send_a(p);
            repeat ($urandom_range(0, 2)) @(negedge clock);
         end
         model(total, 16, e_acc, e_ovf);
         result_a("rand_a", e_acc, e_ovf, int'($urandom_range(0, 3)));
      end

      // Randomized pairs on B, overflowing roughly half the time
      for (int g = 0; g < 20; g++) begin
         total = 0;
         for (int k = 0; k < 2; k++) begin
            p = int'($urandom_range(0, 1023));
            total += p;
            send_b(p);
         end
         model(total, 10, e_acc, e_ovf);
         result_b("rand_b", e_acc, e_ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
